// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from vga_timing_gen to the pixel pipeline.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int unsigned HW = 10,
    parameter int unsigned VW = 10
);
    logic          hsync;
    logic          vsync;
    logic          display_on;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic          line_start;
    logic          frame_start;
    logic          fetch_on;
    logic [HW-1:0] fetch_x;
    logic [VW-1:0] fetch_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0]    frame_cnt;
`endif

    modport master (
        output hsync, vsync, display_on, hpos, vpos, line_start, frame_start,
        output fetch_on, fetch_x, fetch_y
`ifdef VGA_TIMING_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input hsync, vsync, display_on, hpos, vpos, line_start, frame_start,
        input fetch_on, fetch_x, fetch_y
`ifdef VGA_TIMING_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, syncs, blanking, strobes and a look-ahead fetch window.
// Optional 8-bit frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter bit          H_POL    = 1'b0,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned PREFETCH = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    vga_timing_gen_if.master   vid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW:0]   H_ACT_W  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   H_TOT_W  = (HW+1)'(H_TOTAL);
    localparam logic [HW:0]   H_SS_W   = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   H_SE_W   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW:0]   PF_W     = (HW+1)'(PREFETCH);
    localparam logic [VW:0]   V_ACT_W  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0]   V_SS_W   = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   V_SE_W   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    // Fetch outputs while in reset: the look-ahead decode of position (0,0).
    localparam bit            RST_WRAP = (PREFETCH >= H_TOTAL);
    localparam logic [HW-1:0] RST_FX   = HW'(RST_WRAP ? PREFETCH - H_TOTAL : PREFETCH);
    localparam logic [VW-1:0] RST_FY   = VW'((RST_WRAP && V_TOTAL > 1) ? 1 : 0);
    localparam bit            RST_FON  = (RST_FX < H_ACTIVE) && (RST_FY < V_ACTIVE);

    logic [HW-1:0] hpos_q, h_nxt, fx_q, fx_d;
    logic [VW-1:0] vpos_q, v_nxt, fy_q, fy_d;
    logic [HW:0]   look;
    logic          h_wrap, v_wrap;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          display_q, display_d, fon_q, fon_d;
    logic          ls_q, fs_q;

    // Decode everything from the next counter value so registered outputs line up with hpos/vpos.
    always_comb begin
        h_wrap = (hpos_q == H_LAST);
        v_wrap = (vpos_q == V_LAST);
        h_nxt  = h_wrap ? '0 : hpos_q + HW'(1);
        v_nxt  = vpos_q;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vpos_q + VW'(1);
        end

        hsync_d   = (({1'b0, h_nxt} >= H_SS_W) && ({1'b0, h_nxt} < H_SE_W)) ? H_POL : ~H_POL;
        vsync_d   = (({1'b0, v_nxt} >= V_SS_W) && ({1'b0, v_nxt} < V_SE_W)) ? V_POL : ~V_POL;
        display_d = ({1'b0, h_nxt} < H_ACT_W) && ({1'b0, v_nxt} < V_ACT_W);

        look = {1'b0, h_nxt} + PF_W;
        fx_d = look[HW-1:0];
        fy_d = v_nxt;
        if (look >= H_TOT_W) begin
            fx_d = HW'(look - H_TOT_W);
            fy_d = (v_nxt == V_LAST) ? '0 : v_nxt + VW'(1);
        end
        fon_d = ({1'b0, fx_d} < H_ACT_W) && ({1'b0, fy_d} < V_ACT_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q    <= '0;
            vpos_q    <= '0;
            hsync_q   <= ~H_POL;
            vsync_q   <= ~V_POL;
            display_q <= 1'b1;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            fon_q     <= RST_FON;
            fx_q      <= RST_FX;
            fy_q      <= RST_FY;
        end else begin
            ls_q <= ce & h_wrap;
            fs_q <= ce & h_wrap & v_wrap;
            if (ce) begin
                hpos_q    <= h_nxt;
                vpos_q    <= v_nxt;
                hsync_q   <= hsync_d;
                vsync_q   <= vsync_d;
                display_q <= display_d;
                fon_q     <= fon_d;
                fx_q      <= fx_d;
                fy_q      <= fy_d;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (ce && h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign vid.frame_cnt = frame_cnt_q;
`endif

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.display_on  = display_q;
    assign vid.hpos        = hpos_q;
    assign vid.vpos        = vpos_q;
    assign vid.line_start  = ls_q;
    assign vid.frame_start = fs_q;
    assign vid.fetch_on    = fon_q;
    assign vid.fetch_x     = fx_q;
    assign vid.fetch_y     = fy_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator.
- Produces hsync/vsync, pixel coordinates, blanking, line/frame strobes and a look-ahead fetch window for pipelined pixel sources such as glyph ROMs.
- A pixel clock-enable lets it run from a faster system clock.
- Sits between the clock/reset pins and the pixel pipeline in every video top-level.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- H_POL, 0, hsync active level (0 = negative, 1 = positive)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync height (lines)
- V_BP, 33, vertical back porch (lines)
- V_POL, 0, vsync active level
- PREFETCH, 0, fetch look-ahead in pixel ticks; legal range 0..H_FP+H_SYNC+H_BP
- Derived values (localparams, not user-settable):
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
- clk, input, 1: system clock; one clock.
- rst_n, input, 1: asynchronous, active-low reset.
- ce, input, 1: pixel-tick enable; all state advances only on clk edges with ce=1.
- hsync, output, 1: horizontal sync, polarity set by H_POL.
- vsync, output, 1: vertical sync, polarity set by V_POL.
- display_on, output, 1: current (hpos,vpos) lies in the visible area.
- hpos, output, HW: current pixel column.
- vpos, output, VW: current line.
- line_start, output, 1: one-clk strobe on entry to hpos=0.
- frame_start, output, 1: one-clk strobe on entry to (0,0).
- fetch_on, output, 1: the pixel PREFETCH ticks ahead is visible.
- fetch_x, output, HW: column of the pixel PREFETCH ticks ahead; valid while fetch_on=1.
- fetch_y, output, VW: line of that look-ahead pixel.

Behaviour:
- Every output is a register. Sync, blanking and fetch outputs are decoded from the next counter value, so they are coherent with hpos/vpos in the same cycle (zero skew).
- Reset (rst_n=0, asynchronous):
  - hpos=0, vpos=0, display_on=1.
  - hsync=~H_POL, vsync=~V_POL.
  - line_start=0, frame_start=0.
  - fetch_on/fetch_x/fetch_y = their decode of position (0,0)+PREFETCH.
- Counting, on a clk edge with ce=1:
  - hpos = (hpos==H_TOTAL-1) ? 0 : hpos+1.
  - On horizontal wrap: vpos = (vpos==V_TOTAL-1) ? 0 : vpos+1; otherwise vpos holds.
- On a clk edge with ce=0: hpos, vpos, hsync, vsync, display_on and the fetch outputs all hold.
- Strobes:
  - line_start is 1 for exactly one clk after the ce edge that sets hpos to 0; 0 on every other clk, including ce=0 clks.
  - frame_start behaves the same way for the edge that sets (hpos,vpos) to (0,0).
- hsync is at its active level iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
- vsync is at its active level iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC. vsync changes together with hpos=0.
- display_on = (hpos<H_ACTIVE) && (vpos<V_ACTIVE).
- Fetch window:
  - Look-ahead position: p = hpos+PREFETCH.
  - If p >= H_TOTAL: fetch_x = p-H_TOTAL and fetch_y = next line (vpos+1, wrapping V_TOTAL-1→0).
  - Otherwise: fetch_x = p and fetch_y = vpos.
  - fetch_on = (fetch_x<H_ACTIVE) && (fetch_y<V_ACTIVE).
  - With PREFETCH=0: fetch_on==display_on, fetch_x==hpos, fetch_y==vpos.
- Arithmetic:
  - Comparisons are unsigned, evaluated at HW/VW widths.
  - Look-ahead sums use HW+1 bits to avoid overflow.
- Reset mid-frame: all outputs return to the reset values immediately. Counting restarts from (0,0) on the first ce edge after rst_n rises. No strobe is emitted for the reset itself.
- Non-power-of-two totals: counters never reach the unused codes.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt [7:0].
  - Resets to 0.
  - Increments (mod 256) in the same clk that frame_start is asserted.
  - Intended for blink/animation timing.
- Undefined: the port does not exist; no extra flops are generated.

Test Plan:
- Reset, defaults, ce=1 → hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, both strobes 0.
- Free-run one line → hsync=0 exactly for hpos 656..751; display_on=0 from hpos 640; after hpos 799 the next value is 0 with vpos=1 and line_start high for one clk.
- Free-run a full frame → vsync=0 exactly on lines 490..491; after (799,524) the counters return to (0,0) with frame_start high for one clk; period 420000 ce ticks.
- ce toggling 1,0,0,1 → counters advance by 2 over 4 clks; strobes stay one clk wide; outputs hold during ce=0.
- PREFETCH=2 → at (798,524): fetch_on=1, fetch_x=0, fetch_y=0; at (638,10): fetch_on=0; at (637,10): fetch_x=639, fetch_on=1.
- rst_n pulsed low at (300,200) → outputs return to reset values asynchronously; first ce edge after release gives hpos=1, vpos=0; with VGA_TIMING_FRAME_CNT_EN defined, frame_cnt reads 0 after reset and 3 after three full frames.
